// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the cooking-time countdown.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_ZERO = 2'd0,
    ST_SET  = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX       = 4'd9;
  localparam logic [3:0] SEC_TENS_WRAP = 4'd5;

  typedef struct packed {
    logic [3:0] mins;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_time_t;

  function automatic logic is_zero(bcd_time_t t);
    return (t == '0);
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Keypad, magnetron-control and display signals of the countdown timer.
interface countdown_timer_if;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       mag_on;
  logic       time_over;
  logic       done;
  logic [3:0] mins;
  logic [3:0] secs_tens;
  logic [3:0] secs_ones;

  modport master (
    output key_valid, key_digit, mag_on,
    input  time_over, done, mins, secs_tens, secs_ones
  );

  modport slave (
    input  key_valid, key_digit, mag_on,
    output time_over, done, mins, secs_tens, secs_ones
  );
endinterface

// File: rtl/countdown_timer_bcd_down_digit.sv
// One BCD digit decrementer; loads WRAP and borrows when decremented from 0.
module bcd_down_digit #(
  parameter logic [3:0] WRAP = 4'd9
) (
  input  logic [3:0] digit,
  input  logic       dec_in,
  output logic [3:0] digit_dec,
  output logic       borrow_out
);

  // Digits 6..9 in the tens position simply count down like any other value.
  always_comb begin
    digit_dec  = digit;
    borrow_out = 1'b0;
    if (dec_in) begin
      if (digit == 4'd0) begin
        digit_dec  = WRAP;
        borrow_out = 1'b1;
      end else begin
        digit_dec = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// M:SS cooking-time countdown: keypad shift-in while idle, one decrement per
// TICK_DIV cycles while the magnetron runs, time_over/done to magnetron control.
//
// state   | meaning
// ST_ZERO | stored time is 0:00
// ST_SET  | nonzero time, magnetron off (entry allowed)
// ST_RUN  | nonzero time, magnetron on (counting down)
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic              clk,
  input  logic              Nreset,
  input  logic              Nclear,
  countdown_timer_if.slave  tif
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_e          state_q, state_d;
  bcd_time_t       time_q, time_d, time_dec, key_time;
  logic [PW-1:0]   presc_q, presc_d;
  logic            time_over_q, time_over_d;
  logic            done_q, done_d;
  logic            count_en, tick, dec_ok, key_ok;
  logic            borrow_ones, borrow_tens, borrow_mins;

  // Counting is enabled on the SET->RUN edge already, so the first tick lands
  // on the TICK_DIV-th edge after mag_on rises.
  assign count_en = tif.mag_on && (state_q != ST_ZERO);
  assign tick     = count_en && (presc_q == PRESC_LAST);
  // A borrow out of the minutes digit would mean decrementing 0:00.
  assign dec_ok   = tick && !borrow_mins;
  assign key_ok   = tif.key_valid && (tif.key_digit <= BCD_MAX) && !tif.mag_on;
  assign key_time = {time_q.tens, time_q.ones, tif.key_digit};

  bcd_down_digit #(.WRAP(BCD_MAX)) u_ones (
    .digit      (time_q.ones),
    .dec_in     (tick),
    .digit_dec  (time_dec.ones),
    .borrow_out (borrow_ones)
  );

  bcd_down_digit #(.WRAP(SEC_TENS_WRAP)) u_tens (
    .digit      (time_q.tens),
    .dec_in     (borrow_ones),
    .digit_dec  (time_dec.tens),
    .borrow_out (borrow_tens)
  );

  bcd_down_digit #(.WRAP(BCD_MAX)) u_mins (
    .digit      (time_q.mins),
    .dec_in     (borrow_tens),
    .digit_dec  (time_dec.mins),
    .borrow_out (borrow_mins)
  );

  // State, time, prescaler and output registers.
  always_ff @(posedge clk or negedge Nreset) begin
    if (!Nreset) begin
      state_q     <= ST_ZERO;
      time_q      <= '0;
      presc_q     <= '0;
      time_over_q <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      time_q      <= time_d;
      presc_q     <= presc_d;
      time_over_q <= time_over_d;
      done_q      <= done_d;
    end
  end

  // Next state: clear beats decrement beats key entry; prescaler idles at 0.
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    presc_d = '0;
    if (!Nclear) begin
      state_d = ST_ZERO;
      time_d  = '0;
    end else if (dec_ok) begin
      time_d  = time_dec;
      state_d = is_zero(time_dec) ? ST_ZERO : ST_RUN;
    end else if (count_en) begin
      presc_d = presc_q + PW'(1);
      state_d = ST_RUN;
    end else if (key_ok) begin
      time_d  = key_time;
      state_d = is_zero(key_time) ? ST_ZERO : ST_SET;
    end else if (state_q == ST_RUN) begin
      state_d = ST_SET;
    end
  end

  // Outputs follow the next-state time so they move with the digits.
  always_comb begin
    time_over_d = is_zero(time_d);
    done_d      = Nclear && dec_ok && is_zero(time_dec);
  end

  assign tif.time_over = time_over_q;
  assign tif.done      = done_q;
  assign tif.mins      = time_q.mins;
  assign tif.secs_tens = time_q.tens;
  assign tif.secs_ones = time_q.ones;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICK_DIV = 4.
module tb_countdown_timer;

  logic clk;
  logic Nreset;
  logic Nclear;
  int   errors;
  int   checks;

  countdown_timer_if tif ();

  countdown_timer #(.TICK_DIV(4)) dut (
    .clk    (clk),
    .Nreset (Nreset),
    .Nclear (Nclear),
    .tif    (tif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       nclear;
    logic       kv;
    logic [3:0] kd;
    logic       mag;
    logic [3:0] m;
    logic [3:0] t;
    logic [3:0] o;
    logic       to;
    logic       dn;
  } vec_t;

  vec_t vecs [28];

  task automatic check(input string name, input logic [3:0] em, input logic [3:0] et,
                       input logic [3:0] eo, input logic eto, input logic edn);
    checks++;
    if ({tif.mins, tif.secs_tens, tif.secs_ones, tif.time_over, tif.done} !==
        {em, et, eo, eto, edn}) begin
      errors++;
      $display("FAIL %s: got %0h:%0h%0h time_over=%b done=%b, expected %0h:%0h%0h time_over=%b done=%b",
               name, tif.mins, tif.secs_tens, tif.secs_ones, tif.time_over, tif.done,
               em, et, eo, eto, edn);
    end
  endtask

  // Drive inputs away from the rising edge, then sample 1 ns after it.
  task automatic step(input logic nc, input logic kv, input logic [3:0] kd, input logic mg);
    @(negedge clk);
    Nclear        = nc;
    tif.key_valid = kv;
    tif.key_digit = kd;
    tif.mag_on    = mg;
    @(posedge clk);
    #1;
  endtask

  task automatic load3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    step(1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b1, 1'b1, a, 1'b0);
    step(1'b1, 1'b1, b, 1'b0);
    step(1'b1, 1'b1, c, 1'b0);
    step(1'b1, 1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    int sec;
    errors        = 0;
    checks        = 0;
    Nreset        = 1'b0;
    Nclear        = 1'b1;
    tif.key_valid = 1'b0;
    tif.key_digit = 4'd0;
    tif.mag_on    = 1'b0;

    //                nc kv kd     mg  m     t     o     to dn
    vecs[0]  = '{1, 1, 4'd1,  0, 4'd0, 4'd0, 4'd1, 0, 0};
    vecs[1]  = '{1, 1, 4'd0,  0, 4'd0, 4'd1, 4'd0, 0, 0};
    vecs[2]  = '{1, 1, 4'd5,  0, 4'd1, 4'd0, 4'd5, 0, 0};
    vecs[3]  = '{1, 0, 4'd0,  0, 4'd1, 4'd0, 4'd5, 0, 0};
    vecs[4]  = '{1, 1, 4'd12, 0, 4'd1, 4'd0, 4'd5, 0, 0};
    vecs[5]  = '{1, 1, 4'd7,  1, 4'd1, 4'd0, 4'd5, 0, 0};
    vecs[6]  = '{1, 0, 4'd0,  1, 4'd1, 4'd0, 4'd5, 0, 0};
    vecs[7]  = '{1, 0, 4'd0,  1, 4'd1, 4'd0, 4'd5, 0, 0};
    vecs[8]  = '{1, 0, 4'd0,  1, 4'd1, 4'd0, 4'd4, 0, 0};
    vecs[9]  = '{1, 1, 4'd3,  1, 4'd1, 4'd0, 4'd4, 0, 0};
    vecs[10] = '{1, 0, 4'd0,  1, 4'd1, 4'd0, 4'd4, 0, 0};
    vecs[11] = '{1, 0, 4'd0,  1, 4'd1, 4'd0, 4'd4, 0, 0};
    vecs[12] = '{1, 0, 4'd0,  1, 4'd1, 4'd0, 4'd3, 0, 0};
    vecs[13] = '{1, 0, 4'd0,  0, 4'd1, 4'd0, 4'd3, 0, 0};
    vecs[14] = '{1, 1, 4'd9,  0, 4'd0, 4'd3, 4'd9, 0, 0};
    vecs[15] = '{0, 0, 4'd0,  0, 4'd0, 4'd0, 4'd0, 1, 0};
    vecs[16] = '{1, 1, 4'd0,  0, 4'd0, 4'd0, 4'd0, 1, 0};
    vecs[17] = '{1, 1, 4'd2,  0, 4'd0, 4'd0, 4'd2, 0, 0};
    vecs[18] = '{1, 0, 4'd0,  1, 4'd0, 4'd0, 4'd2, 0, 0};
    vecs[19] = '{1, 0, 4'd0,  1, 4'd0, 4'd0, 4'd2, 0, 0};
    vecs[20] = '{1, 0, 4'd0,  1, 4'd0, 4'd0, 4'd2, 0, 0};
    vecs[21] = '{1, 0, 4'd0,  1, 4'd0, 4'd0, 4'd1, 0, 0};
    vecs[22] = '{1, 0, 4'd0,  1, 4'd0, 4'd0, 4'd1, 0, 0};
    vecs[23] = '{1, 0, 4'd0,  1, 4'd0, 4'd0, 4'd1, 0, 0};
    vecs[24] = '{1, 0, 4'd0,  1, 4'd0, 4'd0, 4'd1, 0, 0};
    vecs[25] = '{1, 0, 4'd0,  1, 4'd0, 4'd0, 4'd0, 1, 1};
    vecs[26] = '{1, 0, 4'd0,  1, 4'd0, 4'd0, 4'd0, 1, 0};
    vecs[27] = '{1, 1, 4'd5,  0, 4'd0, 4'd0, 4'd5, 0, 0};

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    Nreset = 1'b1;
    #1;
    check("reset", 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);

    // mag_on in ZERO has no effect
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 4'd0, 1'b1);
      check($sformatf("zero_mag%0d", i), 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
    end

    // Table of single-cycle vectors
    for (int i = 0; i < 28; i++) begin
      step(vecs[i].nclear, vecs[i].kv, vecs[i].kd, vecs[i].mag);
      check($sformatf("vec%0d", i), vecs[i].m, vecs[i].t, vecs[i].o, vecs[i].to, vecs[i].dn);
    end

    // Full run from 1:05 down to 0:00 against a seconds-count model
    load3(4'd1, 4'd0, 4'd5);
    check("load_105", 4'd1, 4'd0, 4'd5, 1'b0, 1'b0);
    sec = 65;
    for (int k = 1; k <= 260; k++) begin
      step(1'b1, 1'b0, 4'd0, 1'b1);
      if (k % 4 == 0) sec--;
      check($sformatf("run105_c%0d", k), 4'(sec / 60), 4'((sec % 60) / 10), 4'(sec % 10),
            (sec == 0), (k == 260));
    end
    step(1'b1, 1'b0, 4'd0, 1'b1);
    check("done_one_cycle", 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);

    // Pause keeps time and discards partial second
    load3(4'd0, 4'd0, 4'd3);
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 4'd0, 1'b1);
    check("run6_002", 4'd0, 4'd0, 4'd2, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 4'd0, 1'b0);
    check("paused_002", 4'd0, 4'd0, 4'd2, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'd7, 1'b0);
    check("paused_key7", 4'd0, 4'd2, 4'd7, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, 1'b0, 4'd0, 1'b1);
      check($sformatf("resume_c%0d", k), 4'd0, 4'd2, 4'd7, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, 4'd0, 1'b1);
    check("resume_c4", 4'd0, 4'd2, 4'd6, 1'b0, 1'b0);

    // Tens digit above 5 counts down normally, then wraps to 5
    step(1'b1, 1'b0, 4'd0, 1'b0);
    load3(4'd1, 4'd7, 4'd0);
    check("load_170", 4'd1, 4'd7, 4'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 11; i++) begin
      for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 4'd0, 1'b1);
      if (i <= 10) check($sformatf("run170_t%0d", i), 4'd1, 4'd6, 4'(10 - i), 1'b0, 1'b0);
      else         check("run170_t11", 4'd1, 4'd5, 4'd9, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, 4'd0, 1'b0);
    load3(4'd1, 4'd0, 4'd0);
    check("load_100", 4'd1, 4'd0, 4'd0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 4'd0, 1'b1);
    check("run100_059", 4'd0, 4'd5, 4'd9, 1'b0, 1'b0);

    // Clear during RUN
    step(1'b1, 1'b0, 4'd0, 1'b0);
    load3(4'd0, 4'd4, 4'd5);
    step(1'b1, 1'b0, 4'd0, 1'b1);
    step(1'b1, 1'b0, 4'd0, 1'b1);
    check("pre_clear", 4'd0, 4'd4, 4'd5, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'd0, 1'b1);
    check("clear_run", 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'd0, 1'b1);
    check("after_clear", 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);

    // Asynchronous reset mid-count
    step(1'b1, 1'b0, 4'd0, 1'b0);
    load3(4'd0, 4'd4, 4'd5);
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 4'd0, 1'b1);
    check("pre_reset", 4'd0, 4'd4, 4'd4, 1'b0, 1'b0);
    @(negedge clk);
    #2 Nreset = 1'b0;
    #1;
    check("async_reset", 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
    @(negedge clk);
    Nreset = 1'b1;
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 4'd0, 1'b1);
    check("post_reset", 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
